cnn_layer_accel_weight_sequencer: RTL and testbench



---
 rtl/cnn_layer_accel_wht_seq_pkg.sv | 18 +
 rtl/cnn_layer_accel_wht_seq_if.sv | 21 ++
 rtl/cnn_layer_accel_wht_seq_ram.sv | 48 ++++
 rtl/cnn_layer_accel_weight_sequencer.sv | 161 ++++++++++++++++
 tb/tb_cnn_layer_accel_weight_sequencer.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_layer_accel_wht_seq_pkg.sv
// Shared types and helpers for the weight-address sequencer.
// Parameters stay on the modules; this holds only width-free items.
package cnn_layer_accel_wht_seq_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Power-up table content: each entry points at its own index.
    function automatic int unsigned dflt_entry(
        input int unsigned idx,
        input int unsigned w
    );
        return idx % (32'd1 << w);
    endfunction

endpackage

// File: rtl/cnn_layer_accel_wht_seq_if.sv
// Weight-address stream from the sequencer to the weight-buffer read port.
// master = producer (sequencer), slave = consumer (weight buffer).
interface cnn_layer_accel_wht_seq_if #(
    parameter int WHT_ADDR_W = 4
);
    logic                  valid;
    logic                  ready;
    logic [WHT_ADDR_W-1:0] addr;
    logic                  last;
    logic                  pass_end;

    modport master (
        output valid, addr, last, pass_end,
        input  ready
    );

    modport slave (
        input  valid, addr, last, pass_end,
        output ready
    );
endinterface

// File: rtl/cnn_layer_accel_wht_seq_ram.sv
// Sequence table: NUM_SEQ x SEQ_DEPTH entries, one write port and one
// registered read port; reset restores the identity table.
module cnn_layer_accel_wht_seq_ram
    import cnn_layer_accel_wht_seq_pkg::*;
#(
    parameter int NUM_SEQ    = 4,
    parameter int SEQ_DEPTH  = 8,
    parameter int WHT_ADDR_W = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en_i,
    input  logic [$clog2(NUM_SEQ)-1:0]   wr_seq_i,
    input  logic [$clog2(SEQ_DEPTH)-1:0] wr_idx_i,
    input  logic [WHT_ADDR_W-1:0]        wr_data_i,
    input  logic                         rd_en_i,
    input  logic [$clog2(NUM_SEQ)-1:0]   rd_seq_i,
    input  logic [$clog2(SEQ_DEPTH)-1:0] rd_idx_i,
    output logic [WHT_ADDR_W-1:0]        rd_data_o
);
    logic [WHT_ADDR_W-1:0] mem_q [NUM_SEQ][SEQ_DEPTH];
    logic [WHT_ADDR_W-1:0] rd_q;
    logic [WHT_ADDR_W-1:0] rd_d;
    logic                  hit;

    // A same-cycle write to the entry being read is forwarded.
    always_comb begin
        hit  = wr_en_i && (wr_seq_i == rd_seq_i) && (wr_idx_i == rd_idx_i);
        rd_d = hit ? wr_data_i : mem_q[rd_seq_i][rd_idx_i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_SEQ; s++) begin
                for (int i = 0; i < SEQ_DEPTH; i++) begin
                    mem_q[s][i] <= WHT_ADDR_W'(dflt_entry(i, WHT_ADDR_W));
                end
            end
            rd_q <= '0;
        end else begin
            if (wr_en_i) mem_q[wr_seq_i][wr_idx_i] <= wr_data_i;
            if (rd_en_i) rd_q <= rd_d;
        end
    end

    assign rd_data_o = rd_q;

endmodule

// File: rtl/cnn_layer_accel_weight_sequencer.sv
// Self-stepping weight-address sequencer: replays a stored sequence, or
// ping-pongs a sequence pair, for a programmed number of passes.
module cnn_layer_accel_weight_sequencer
    import cnn_layer_accel_wht_seq_pkg::*;
#(
    parameter int NUM_SEQ    = 4,
    parameter int SEQ_DEPTH  = 8,
    parameter int WHT_ADDR_W = 4,
    parameter int RPT_W      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_wr_en_i,
    input  logic [$clog2(NUM_SEQ)-1:0]   cfg_wr_seq_i,
    input  logic [$clog2(SEQ_DEPTH)-1:0] cfg_wr_idx_i,
    input  logic [WHT_ADDR_W-1:0]        cfg_wr_data_i,
    output logic                         cfg_wr_err_o,
    input  logic                         start_i,
    input  logic                         abort_i,
    input  logic [$clog2(NUM_SEQ)-1:0]   seq_sel_i,
    input  logic [$clog2(SEQ_DEPTH)-1:0] seq_len_m1_i,
    input  logic [RPT_W-1:0]             rpt_m1_i,
    input  logic                         pingpong_i,
    cnn_layer_accel_wht_seq_if.master    wht,
    output logic                         busy_o,
    output logic                         done_o
);
    localparam int SW = $clog2(NUM_SEQ);
    localparam int IW = $clog2(SEQ_DEPTH);

    state_e           state_q, state_d;
    logic [SW-1:0]    base_q, base_d;
    logic [IW-1:0]    len_q, len_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic [RPT_W-1:0] pass_q, pass_d;
    logic             pp_q, pp_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             pend_q, pend_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             hs, go, fin, load;
    logic [SW-1:0]    rd_seq;
    logic             wr_ok;

    assign hs    = valid_q & wht.ready;
    assign go    = (state_q == ST_IDLE) & start_i & ~abort_i;
    assign fin   = (state_q == ST_RUN) & (abort_i | (hs & last_q));
    assign wr_ok = cfg_wr_en_i & (state_q == ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (go)  state_d = ST_RUN;
            ST_RUN:  if (fin) state_d = ST_IDLE;
            default:          state_d = ST_IDLE;
        endcase
    end

    // Next beat position; the table read address derives from it directly.
    always_comb begin
        base_d  = base_q;
        len_d   = len_q;
        rpt_d   = rpt_q;
        pp_d    = pp_q;
        idx_d   = idx_q;
        pass_d  = pass_q;
        valid_d = valid_q;
        last_d  = last_q;
        pend_d  = pend_q;
        load    = 1'b0;
        done_d  = (state_q == ST_RUN) & ~abort_i & hs & last_q;
        err_d   = cfg_wr_en_i & (state_q == ST_RUN);
        if (go) begin
            base_d = seq_sel_i;
            len_d  = seq_len_m1_i;
            rpt_d  = rpt_m1_i;
            pp_d   = pingpong_i;
            idx_d  = '0;
            pass_d = '0;
            load   = 1'b1;
        end else if (fin) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            pend_d  = 1'b0;
        end else if ((state_q == ST_RUN) && hs) begin
            load = 1'b1;
            if (idx_q == len_q) begin
                idx_d  = '0;
                pass_d = pass_q + 1'b1;
            end else begin
                idx_d  = idx_q + 1'b1;
            end
        end
        if (load) begin
            valid_d = 1'b1;
            pend_d  = (idx_d == len_d);
            last_d  = pend_d & (pass_d == rpt_d);
        end
        rd_seq = base_d ^ SW'(pp_d & pass_d[0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q  <= '0;
            len_q   <= '0;
            rpt_q   <= '0;
            pp_q    <= 1'b0;
            idx_q   <= '0;
            pass_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            base_q  <= base_d;
            len_q   <= len_d;
            rpt_q   <= rpt_d;
            pp_q    <= pp_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    cnn_layer_accel_wht_seq_ram #(
        .NUM_SEQ    (NUM_SEQ),
        .SEQ_DEPTH  (SEQ_DEPTH),
        .WHT_ADDR_W (WHT_ADDR_W)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_ok),
        .wr_seq_i  (cfg_wr_seq_i),
        .wr_idx_i  (cfg_wr_idx_i),
        .wr_data_i (cfg_wr_data_i),
        .rd_en_i   (load),
        .rd_seq_i  (rd_seq),
        .rd_idx_i  (idx_d),
        .rd_data_o (wht.addr)
    );

    assign wht.valid    = valid_q;
    assign wht.last     = last_q;
    assign wht.pass_end = pend_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = done_q;
    assign cfg_wr_err_o = err_q;

endmodule

// File: tb/tb_cnn_layer_accel_weight_sequencer.sv
// Bench for the weight sequencer: table vectors, hand sequences and random
// runs checked against a queue-based model of the sequence table.
module tb_cnn_layer_accel_weight_sequencer;

    localparam int BUDGET = 10000;

    typedef struct {
        int addr;
        bit pend;
        bit last;
    } beat_t;

    typedef struct {
        int sel;
        int len;
        int rpt;
        bit pp;
        int duty;
        int abort_at;
        int wr_at;
        int exp_beats;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_wr_en_i = 1'b0;
    logic [1:0] cfg_wr_seq_i = '0;
    logic [2:0] cfg_wr_idx_i = '0;
    logic [3:0] cfg_wr_data_i = '0;
    logic       cfg_wr_err_o;
    logic       start_i = 1'b0;
    logic       abort_i = 1'b0;
    logic [1:0] seq_sel_i = '0;
    logic [2:0] seq_len_m1_i = '0;
    logic [7:0] rpt_m1_i = '0;
    logic       pingpong_i = 1'b0;
    logic       busy_o;
    logic       done_o;

    cnn_layer_accel_wht_seq_if #(.WHT_ADDR_W(4)) wht_bus ();

    cnn_layer_accel_weight_sequencer #(
        .NUM_SEQ(4), .SEQ_DEPTH(8), .WHT_ADDR_W(4), .RPT_W(8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_wr_en_i   (cfg_wr_en_i),
        .cfg_wr_seq_i  (cfg_wr_seq_i),
        .cfg_wr_idx_i  (cfg_wr_idx_i),
        .cfg_wr_data_i (cfg_wr_data_i),
        .cfg_wr_err_o  (cfg_wr_err_o),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .seq_sel_i     (seq_sel_i),
        .seq_len_m1_i  (seq_len_m1_i),
        .rpt_m1_i      (rpt_m1_i),
        .pingpong_i    (pingpong_i),
        .wht           (wht_bus),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int tbl [4][8];
    int got_q [$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int s = 0; s < 4; s++)
            for (int i = 0; i < 8; i++)
                tbl[s][i] = i % 16;
    endtask

    task automatic cfg_write(input int s, input int i, input int d);
        cfg_wr_en_i   = 1'b1;
        cfg_wr_seq_i  = 2'(s);
        cfg_wr_idx_i  = 3'(i);
        cfg_wr_data_i = 4'(d);
        tick();
        cfg_wr_en_i = 1'b0;
        tbl[s][i] = d;
        chk("wr_err_idle", 32'(cfg_wr_err_o), 0);
    endtask

    task automatic run(input int sel, input int len, input int rpt,
                       input bit pp, input int duty, input int abort_at,
                       input int wr_at, input int same_wr,
                       output int nbeats);
        beat_t      exp_q [$];
        beat_t      e;
        int         s, cyc;
        bit         stalled, aborted, err_exp, rdy, ab, vld;
        logic [3:0] p_addr;
        logic       p_last, p_pend;
        nbeats = 0;
        got_q.delete();
        start_i      = 1'b1;
        seq_sel_i    = 2'(sel);
        seq_len_m1_i = 3'(len);
        rpt_m1_i     = 8'(rpt);
        pingpong_i   = pp;
        wht_bus.ready = 1'b0;
        if (same_wr >= 0) begin
            cfg_wr_en_i   = 1'b1;
            cfg_wr_seq_i  = 2'(sel);
            cfg_wr_idx_i  = 3'd0;
            cfg_wr_data_i = 4'(same_wr);
            tbl[sel][0]   = same_wr;
        end
        for (int p = 0; p <= rpt; p++) begin
            s = sel ^ ((pp && (p % 2 == 1)) ? 1 : 0);
            for (int i = 0; i <= len; i++)
                exp_q.push_back('{tbl[s][i], i == len, i == len && p == rpt});
        end
        tick();
        start_i = 1'b0;
        cfg_wr_en_i = 1'b0;
        seq_sel_i    = 2'($urandom);
        seq_len_m1_i = 3'($urandom);
        rpt_m1_i     = 8'($urandom);
        pingpong_i   = 1'($urandom);
        chk("busy_after_start", 32'(busy_o), 1);
        cyc = 0; stalled = 0; aborted = 0; err_exp = 0;
        p_addr = '0; p_last = 0; p_pend = 0;
        while (exp_q.size() > 0 && !aborted && cyc < BUDGET) begin
            chk("wr_err", 32'(cfg_wr_err_o), 32'(err_exp));
            err_exp = 0;
            vld = wht_bus.valid;
            chk("valid", 32'(vld), 1);
            e = exp_q[0];
            chk("addr", 32'(wht_bus.addr), 32'(e.addr));
            chk("pass_end", 32'(wht_bus.pass_end), 32'(e.pend));
            chk("last", 32'(wht_bus.last), 32'(e.last));
            if (stalled)
                chk("stall_hold", 32'({wht_bus.addr, wht_bus.last, wht_bus.pass_end}),
                    32'({p_addr, p_last, p_pend}));
            p_addr = wht_bus.addr;
            p_last = wht_bus.last;
            p_pend = wht_bus.pass_end;
            rdy = ($urandom_range(99) < duty);
            ab  = (abort_at >= 0 && nbeats == abort_at);
            if (ab) rdy = 1;
            wht_bus.ready = rdy;
            abort_i = ab;
            if (wr_at == cyc) begin
                cfg_wr_en_i   = 1'b1;
                cfg_wr_seq_i  = 2'(sel);
                cfg_wr_idx_i  = 3'd0;
                cfg_wr_data_i = 4'(tbl[sel][0] + 1);
                err_exp = 1;
            end
            tick();
            cfg_wr_en_i = 1'b0;
            abort_i = 1'b0;
            if (rdy && vld) begin
                got_q.push_back(int'(p_addr));
                void'(exp_q.pop_front());
                nbeats++;
            end
            stalled = !rdy;
            aborted = ab;
            cyc++;
        end
        wht_bus.ready = 1'b0;
        chk("no_timeout", 32'(cyc < BUDGET), 1);
        chk("wr_err_end", 32'(cfg_wr_err_o), 32'(err_exp));
        chk("valid_end", 32'(wht_bus.valid), 0);
        chk("busy_end", 32'(busy_o), 0);
        chk("done_end", 32'(done_o), aborted ? 0 : 1);
        tick();
        chk("done_pulse", 32'(done_o), 0);
    endtask

    vec_t vecs [8];
    int   nb;
    int   pp_exp [20];
    int   def_exp [5];

    initial begin
        vecs[0] = '{1, 4,   3, 1,  50, -1, -1,   20};
        vecs[1] = '{3, 7,   1, 0, 100, -1, -1,   16};
        vecs[2] = '{0, 0,   2, 0, 100, -1, -1,    3};
        vecs[3] = '{2, 4,   1, 0, 100,  2, -1,    3};
        vecs[4] = '{2, 4,   1, 0, 100, -1, -1,   10};
        vecs[5] = '{1, 6,   2, 1,  50, -1,  3,   21};
        vecs[6] = '{1, 6,   0, 0,  50, -1, -1,    7};
        vecs[7] = '{0, 7, 255, 1,  70, -1, -1, 2048};
        pp_exp  = '{1, 9, 3, 4, 5, 9, 2, 3, 4, 5,
                    1, 9, 3, 4, 5, 9, 2, 3, 4, 5};
        def_exp = '{0, 1, 2, 3, 4};
        wht_bus.ready = 1'b0;
        model_reset();
        tick();
        chk("rst_valid", 32'(wht_bus.valid), 0);
        chk("rst_addr", 32'(wht_bus.addr), 0);
        chk("rst_last", 32'(wht_bus.last), 0);
        chk("rst_pend", 32'(wht_bus.pass_end), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_err", 32'(cfg_wr_err_o), 0);
        tick();
        rst = 1'b0;
        tick();

        run(2, 4, 0, 0, 100, -1, -1, -1, nb);
        chk("default_beats", 32'(nb), 5);
        for (int i = 0; i < 5 && i < got_q.size(); i++)
            chk("default_addr", 32'(got_q[i]), 32'(def_exp[i]));

        cfg_write(0, 0, 1); cfg_write(0, 1, 9); cfg_write(0, 2, 3);
        cfg_write(0, 3, 4); cfg_write(0, 4, 5);
        cfg_write(1, 0, 9); cfg_write(1, 1, 2); cfg_write(1, 2, 3);
        cfg_write(1, 3, 4); cfg_write(1, 4, 5);
        run(0, 4, 3, 1, 100, -1, -1, -1, nb);
        chk("pingpong_beats", 32'(nb), 20);
        for (int i = 0; i < 20 && i < got_q.size(); i++)
            chk("pingpong_addr", 32'(got_q[i]), 32'(pp_exp[i]));

        for (int v = 0; v < 8; v++) begin
            run(vecs[v].sel, vecs[v].len, vecs[v].rpt, vecs[v].pp,
                vecs[v].duty, vecs[v].abort_at, vecs[v].wr_at, -1, nb);
            chk("vec_beats", 32'(nb), 32'(vecs[v].exp_beats));
        end

        run(3, 2, 0, 0, 100, -1, -1, 11, nb);
        chk("wr_start_beats", 32'(nb), 3);
        if (got_q.size() > 0) chk("wr_start_first", 32'(got_q[0]), 11);

        for (int r = 0; r < 12; r++) begin
            int sel, len, rpt, total, ab, wr, exp_n;
            bit pp;
            cfg_write(int'($urandom_range(3)), int'($urandom_range(7)),
                      int'($urandom_range(15)));
            sel = int'($urandom_range(3));
            len = int'($urandom_range(7));
            rpt = int'($urandom_range(3));
            pp  = 1'($urandom);
            total = (len + 1) * (rpt + 1);
            ab = ($urandom_range(3) == 0) ? int'($urandom_range(total - 1)) : -1;
            wr = ($urandom_range(1) == 0) ? int'($urandom_range(6)) : -1;
            exp_n = (ab >= 0) ? ab + 1 : total;
            run(sel, len, rpt, pp, int'($urandom_range(30, 100)), ab, wr, -1, nb);
            chk("rand_beats", 32'(nb), 32'(exp_n));
        end

        start_i = 1'b1; seq_sel_i = 2'd0; seq_len_m1_i = 3'd7;
        rpt_m1_i = 8'd5; pingpong_i = 1'b0;
        wht_bus.ready = 1'b1;
        tick();
        start_i = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(wht_bus.valid), 0);
        chk("midrst_busy", 32'(busy_o), 0);
        wht_bus.ready = 1'b0;
        tick();
        rst = 1'b0;
        model_reset();
        tick();
        run(0, 3, 0, 0, 100, -1, -1, -1, nb);
        chk("post_rst_beats", 32'(nb), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++)
            chk("post_rst_addr", 32'(got_q[i]), 32'(i));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
